// File: rtl/sync_updown_counter.sv
// rtl/sync_updown_counter.sv - loadable mod-N up/down counter with cascadable terminal count
// The load value is clamped to MODULUS-1, so q can never leave 0..MODULUS-1.
module sync_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] load_val;

  // A full-range modulus needs no clamp, and the compare would be constant.
  generate
    if (MODULUS < (2 ** WIDTH)) begin : g_clamp
      assign load_val = (d > MAX_VAL) ? MAX_VAL : d;
    end else begin : g_noclamp
      assign load_val = d;
    end
  endgenerate

  always_comb begin
    tc = en & ((up_dn & (count_q == MAX_VAL)) | (~up_dn & (count_q == '0)));
  end

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      if (up_dn) begin
        if (count_q == MAX_VAL) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          count_d = MAX_VAL;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign q    = count_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_sync_updown_counter.sv
// tb/tb_sync_updown_counter.sv - scoreboard bench for mod-16, mod-10 and cascaded counters
module tb_sync_updown_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0, en = 1'b0, up_dn = 1'b0, load = 1'b0;
  logic [3:0] d = 4'd0;

  logic [3:0] qa, qb, qc1, qc2;
  logic       tca, tcb, tcc1, tcc2, wa, wb, wc1, wc2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int qa;
    int wa;
    int qb;
    int wb;
    int qc;
  } exp_t;

  exp_t sb[$];
  int   ma = 0, mb = 0, mc = 0;
  bit   stim_done = 0;

  always #5 clk = ~clk;

  sync_updown_counter #(.WIDTH(4), .MODULUS(16)) dut_a (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .d(d),
    .q(qa), .tc(tca), .wrap(wa));

  sync_updown_counter #(.WIDTH(4), .MODULUS(10)) dut_b (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .d(d),
    .q(qb), .tc(tcb), .wrap(wb));

  sync_updown_counter #(.WIDTH(4), .MODULUS(16)) cas_lo (
    .clk(clk), .reset(reset), .en(en), .up_dn(1'b1), .load(1'b0), .d(4'd0),
    .q(qc1), .tc(tcc1), .wrap(wc1));

  sync_updown_counter #(.WIDTH(4), .MODULUS(16)) cas_hi (
    .clk(clk), .reset(reset), .en(tcc1), .up_dn(1'b1), .load(1'b0), .d(4'd0),
    .q(qc2), .tc(tcc2), .wrap(wc2));

  function automatic int nxt(int q, int m, bit r, bit l, bit e, bit u, int dv);
    if (r) return 0;
    if (l) return (dv > m - 1) ? m - 1 : dv;
    if (!e) return q;
    return u ? (q + 1) % m : (q + m - 1) % m;
  endfunction

  function automatic int wrp(int q, int m, bit r, bit l, bit e, bit u);
    return (!r && !l && e && (u ? (q == m - 1) : (q == 0))) ? 1 : 0;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(bit r, bit l, bit e, bit u, int dv);
    exp_t x;
    reset = r; load = l; en = e; up_dn = u; d = 4'(dv);
    @(posedge clk);
    x.wa = wrp(ma, 16, r, l, e, u);
    x.wb = wrp(mb, 10, r, l, e, u);
    ma = nxt(ma, 16, r, l, e, u, dv);
    mb = nxt(mb, 10, r, l, e, u, dv);
    mc = r ? 0 : (e ? (mc + 1) % 256 : mc);
    x.qa = ma; x.qb = mb; x.qc = mc;
    sb.push_back(x);
    #1;
  endtask

  // Monitor: pops one expectation per edge; tc is judged against the inputs now applied.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("qa", int'(qa), x.qa);
        chk("wrap_a", int'(wa), x.wa);
        chk("qb", int'(qb), x.qb);
        chk("wrap_b", int'(wb), x.wb);
        chk("cascade", int'({qc2, qc1}), x.qc);
        chk("tc_a", int'(tca), int'(en && (up_dn ? x.qa == 15 : x.qa == 0)));
        chk("tc_b", int'(tcb), int'(en && (up_dn ? x.qb == 9 : x.qb == 0)));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    repeat (20) step(0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0);
    repeat (12) step(0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 7);
    step(0, 1, 0, 1, 12);
    step(1, 1, 1, 1, 5);
    step(0, 1, 0, 1, 5);
    repeat (3) step(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, (i % 2) == 0, 0);
    step(0, 1, 0, 1, 11);
    step(0, 0, 1, 1, 0);
    step(1, 0, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    step(1, 0, 0, 1, 0);
    repeat (300) step(0, 0, 1, 1, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 15)));
    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_updown_counter.md
Name: sync_updown_counter

Overview:
- Synchronous, loadable, mod-N up/down counter. It is the down-counting and synchronous counterpart of the lab's ripple up-counter.
- All state changes on the rising edge of one clock.
- Terminal-count output allows several instances to be cascaded into wider counters.
- Used in the lab sequence as the reference counter that ripple-counter results are compared against.

Parameters:
WIDTH, 4, bit width of count register and load data
MODULUS, 16, count range 0..MODULUS-1; legal range 2..2**WIDTH

Ports:
clk      input   1      rising-edge clock
reset    input   1      synchronous, active-high reset
en       input   1      count enable; counts one step per clk when high
up_dn    input   1      direction: 1 = count up, 0 = count down
load     input   1      synchronous parallel load strobe
d        input   WIDTH  parallel load value
q        output  WIDTH  current count (registered)
tc       output  1      terminal count (combinational from q, en, up_dn)
wrap     output  1      registered one-cycle pulse: previous edge wrapped the count

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high. It is sampled only on the rising edge of clk; asserting it between edges has no effect until the next edge.
- Reset values: q = 0, wrap = 0. tc then follows its equation (tc = 1 if en=1 and up_dn=0, since q=0).
- Per-edge priority: reset > load > en > hold.
- reset=1:
  - q <= 0, wrap <= 0.
  - load and en are ignored.
- load=1 (reset=0):
  - q <= d if d <= MODULUS-1, else q <= MODULUS-1 (clamp).
  - wrap <= 0.
  - en and up_dn are ignored that cycle.
- en=1, up_dn=1 (count up):
  - q <= q+1 if q < MODULUS-1.
  - Otherwise q <= 0 and wrap <= 1.
- en=1, up_dn=0 (count down):
  - q <= q-1 if q > 0.
  - Otherwise q <= MODULUS-1 and wrap <= 1.
- en=1 with no wrap: wrap <= 0.
- en=0: q holds, wrap <= 0.
- tc = en & ((up_dn & q==MODULUS-1) | (~up_dn & q==0)).
  - Purely combinational, no registered delay.
  - High exactly in the cycle before a wrapping edge. Drives en of the next cascaded stage.
- wrap timing: high for exactly the one cycle after the edge that wrapped. It equals the registered value of (tc & ~load & ~reset).
- Latency: q reflects any action on the edge where it is sampled; zero extra pipeline stages.
- Direction change: up_dn may change every cycle; each edge uses the up_dn value sampled on that edge. No glitch or skipped state.
- Arithmetic:
  - All compares and increments are done at WIDTH bits.
  - With MODULUS = 2**WIDTH, wrap occurs at natural overflow (15 -> 0 and 0 -> 15 for WIDTH=4).
  - q must never hold a value >= MODULUS, from any input sequence.
- Reset mid-count: an edge with reset=1 forces q=0 regardless of en, load or current value. Counting resumes from 0 on the first edge with reset=0 and en=1.

Test Plan:
- Reset then up-count: reset=1 for 2 edges, then en=1, up_dn=1 for 20 edges -> q = 0,1,..,15,0,1,2,3. tc=1 while q=15. wrap=1 only in the cycle with q=0 after 15.
- Down-count with MODULUS=10: reset, en=1, up_dn=0 -> q = 9,8,..,0,9. tc=1 while q=0. wrap pulses once per 10 edges. q never exceeds 9.
- Load priority and clamp (MODULUS=10):
  - load=1, d=7, en=1 -> q=7, no wrap.
  - load=1, d=12 -> q=9.
  - reset=1 together with load=1, d=5 -> q=0.
- Hold and direction flip:
  - At q=5, en=0 for 3 edges -> q stays 5, tc=0, wrap=0.
  - Then en=1 with up_dn toggling each edge -> q = 6,5,6,5.
- Cascade: two instances, WIDTH=4, MODULUS=16; stage 2 en = stage 1 tc; 300 up edges from 0 -> {q2,q1} counts 0..255 then 0..43. q2 increments only on edges where q1 goes 15 -> 0.
- Mid-count reset: at q=11 counting up, assert reset for 1 edge -> q=0 on that edge, wrap=0. Next edge with en=1 -> q=1.
